serial_frame_rx: RTL

- Receive side of the 4-bit serial link. The transmit side is a universal shift register in shift-left mode, which puts Q[3] on the line first, so frames arrive MSB first.
- Samples one line bit per enable strobe, checks start, parity and stop framing, and reassembles the parallel word.
- Presents each word on a valid/ready output register that feeds the downstream parallel-load consumer.

---
 rtl/serial_link_pkg.sv | 16 +
 rtl/rx_out_buf.sv | 41 ++++
 rtl/serial_frame_rx.sv | 105 ++++++++++
 3 files changed

// File: rtl/serial_link_pkg.sv
// Shared definitions for both ends of the 4-bit serial link.
// The line idles high and frames are start / data MSB-first / optional parity / stop.
package serial_link_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      PARITY,
      STOP
   } rx_state_t;

   localparam logic LINE_IDLE = 1'b1;
   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/rx_out_buf.sv
// Single-entry valid/ready output register for received words.
// A push into a full, unaccepted entry is dropped and flagged with a one-cycle overrun pulse.
module rx_out_buf #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             ready,
   output logic [WIDTH-1:0] data,
   output logic             valid,
   output logic             overrun
);

   logic accept;
   logic room;

   assign accept = valid & ready;
   // An entry being accepted this cycle counts as free space for a simultaneous push.
   assign room   = ~valid | ready;

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         data    <= '0;
         valid   <= 1'b0;
         overrun <= 1'b0;
      end else begin
         overrun <= 1'b0;
         if (push && room) begin
            data  <= push_data;
            valid <= 1'b1;
         end else if (push) begin
            overrun <= 1'b1;
         end else if (accept) begin
            valid <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/serial_frame_rx.sv
// Receive side of the serial link: frame state machine and shifter, followed by
// the output register. A good frame reaches dout one clock after the stop-bit sample.
module serial_frame_rx
   import serial_link_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter bit PARITY_EN = 1'b1
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic             en,
   input  logic             sd,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   input  logic             dout_ready,
   output logic             frame_err,
   output logic             overrun
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   rx_state_t        state, next_state;
   logic [WIDTH-1:0] shreg;
   logic [CW-1:0]    cnt;
   logic             par_bit;
   logic             start_det, shift, cap_par, eval;
   logic             good;
   logic             push;

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      if (en) begin
         case (state)
            IDLE:   if (sd == START_BIT) next_state = DATA;
            DATA: begin
               if (cnt == LAST_BIT) begin
                  if (PARITY_EN) next_state = PARITY;
                  else           next_state = STOP;
               end
            end
            PARITY: next_state = STOP;
            STOP:   next_state = IDLE;
            default: next_state = IDLE;
         endcase
      end
   end

   always_comb begin
      start_det = 1'b0;
      shift     = 1'b0;
      cap_par   = 1'b0;
      eval      = 1'b0;
      if (en) begin
         case (state)
            IDLE:    start_det = (sd == START_BIT);
            DATA:    shift     = 1'b1;
            PARITY:  cap_par   = 1'b1;
            STOP:    eval      = 1'b1;
            default: ;
         endcase
      end
   end

   // Even parity: data bits and parity bit XOR to zero.
   assign good = (sd == STOP_BIT) && (!PARITY_EN || ((^shreg) == par_bit));

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         shreg     <= '0;
         cnt       <= '0;
         par_bit   <= 1'b0;
         frame_err <= 1'b0;
         push      <= 1'b0;
      end else begin
         frame_err <= eval & ~good;
         push      <= eval & good;
         if (start_det) cnt <= '0;
         if (shift) begin
            shreg <= {shreg[WIDTH-2:0], sd};
            cnt   <= cnt + 1'b1;
         end
         if (cap_par) par_bit <= sd;
      end
   end

   // shreg cannot shift on the cycle after STOP (IDLE never shifts), so it is
   // still the completed word when push is seen.
   rx_out_buf #(.WIDTH(WIDTH)) u_out_buf (
      .clk       (clk),
      .clr_n     (clr_n),
      .push      (push),
      .push_data (shreg),
      .ready     (dout_ready),
      .data      (dout),
      .valid     (dout_valid),
      .overrun   (overrun)
   );

endmodule
